// File: rtl/sat_acc_pkg.sv
// Shared definitions for the saturating accumulating adder: FSM state type,
// default clamp bounds and the signed clamp helper used by the datapath.
package sat_acc_pkg;

  // ACC collects beats, OUT holds a finished result until downstream takes it
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam longint SAT_MIN_DEF = 0;
  localparam longint SAT_MAX_DEF = 255;

  // Clamp a signed value into [lo, hi]; 64 bits covers every accumulator width in use
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    logic signed [63:0] res;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_lane_sum.sv
// Combinational sign-extending lane adder: sums NUM_IN signed IN_W lanes at
// ACC_W bits. Shared with the conv bias path, so it carries no state.
module sat_lane_sum
  import sat_acc_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int IN_W   = 34,
  parameter int ACC_W  = 40
) (
  input  logic [NUM_IN*IN_W-1:0] lanes_i,
  output logic signed [ACC_W-1:0] sum_o
);

  // Widen every lane with its sign before adding so the reduction cannot wrap
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum_o = sum_o + ACC_W'($signed(lanes_i[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/sat_acc_adder.sv
// Saturating packet accumulator: adds NUM_IN lanes per beat, accumulates beats
// until in_last, then clamps the total into [SAT_MIN, SAT_MAX] and offers it on
// a valid/ready output. One bubble cycle separates consecutive packets.
// Optional feature macro: SAT_ACC_ROUND_EN adds cfg_shift, a round-half-up
// arithmetic right shift applied to the packet total before the final clamp.
module sat_acc_adder
  import sat_acc_pkg::*;
#(
  parameter int     NUM_IN  = 3,
  parameter int     IN_W    = 34,
  parameter int     ACC_W   = 40,
  parameter int     OUT_W   = 16,
  parameter longint SAT_MIN = SAT_MIN_DEF,
  parameter longint SAT_MAX = SAT_MAX_DEF,
  parameter int     CNT_W   = 8
) (
`ifdef SAT_ACC_ROUND_EN
  input  logic [4:0]             cfg_shift,
`endif
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic [CNT_W-1:0]       out_beats
);

  localparam int     SW      = 64;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        beatCnt_q, beatCnt_d;
  logic                    accOvf_q, accOvf_d;
  logic [OUT_W-1:0]        outData_q, outData_d;
  logic                    outSat_q, outSat_d;
  logic [CNT_W-1:0]        outBeats_q, outBeats_d;

  logic signed [ACC_W-1:0] beatSum;
  logic signed [SW-1:0]    rawSum;
  logic signed [SW-1:0]    accClamped;
  logic signed [SW-1:0]    totalScaled;
  logic signed [SW-1:0]    outClamped;
  logic signed [ACC_W-1:0] total;
  logic                    addOvf;
  logic                    outOfRange;
  logic                    accepted;
  logic [CNT_W-1:0]        cntInc;
`ifdef SAT_ACC_ROUND_EN
  logic signed [ACC_W:0]   rndBias;
  logic signed [ACC_W:0]   rndSum;
`endif

  sat_lane_sum #(
    .NUM_IN (NUM_IN),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W)
  ) uLaneSum (
    .lanes_i (in_data),
    .sum_o   (beatSum)
  );

  assign accepted = in_valid && in_ready;

  // Running total clamped to the accumulator range, then optionally rescaled and clamped to the output range
  always_comb begin
    rawSum     = SW'(acc_q) + SW'(beatSum);
    accClamped = sat_clamp(rawSum, ACC_MIN, ACC_MAX);
    addOvf     = (accClamped != rawSum);
    total      = ACC_W'(accClamped);
`ifdef SAT_ACC_ROUND_EN
    rndBias = '0;
    if (cfg_shift != 5'd0) begin
      rndBias = (ACC_W + 1)'(1) << (cfg_shift - 5'd1);
    end
    rndSum      = (ACC_W + 1)'(total) + rndBias;
    totalScaled = SW'(rndSum >>> cfg_shift);
`else
    totalScaled = SW'(total);
`endif
    outClamped = sat_clamp(totalScaled, SAT_MIN, SAT_MAX);
    outOfRange = (outClamped != totalScaled);
    cntInc     = (&beatCnt_q) ? beatCnt_q : beatCnt_q + 1'b1;
  end

  // Accumulate on plain beats; on the last beat latch the result and start a fresh packet
  always_comb begin
    acc_d      = acc_q;
    beatCnt_d  = beatCnt_q;
    accOvf_d   = accOvf_q;
    outData_d  = outData_q;
    outSat_d   = outSat_q;
    outBeats_d = outBeats_q;
    if (accepted) begin
      if (in_last) begin
        acc_d      = '0;
        beatCnt_d  = '0;
        accOvf_d   = 1'b0;
        outData_d  = OUT_W'(outClamped);
        outSat_d   = outOfRange || accOvf_q || addOvf;
        outBeats_d = cntInc;
      end else begin
        acc_d     = total;
        accOvf_d  = accOvf_q || addOvf;
        beatCnt_d = cntInc;
      end
    end
  end

  // Datapath registers; reset discards any partial sum and any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      beatCnt_q  <= '0;
      accOvf_q   <= 1'b0;
      outData_q  <= '0;
      outSat_q   <= 1'b0;
      outBeats_q <= '0;
    end else begin
      acc_q      <= acc_d;
      beatCnt_q  <= beatCnt_d;
      accOvf_q   <= accOvf_d;
      outData_q  <= outData_d;
      outSat_q   <= outSat_d;
      outBeats_q <= outBeats_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave ACC on the last-beat handshake, leave OUT once downstream takes the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accepted && in_last) state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Handshake outputs follow the state directly; the result registers hold while OUT waits
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == OUT);
    out_data  = outData_q;
    out_sat   = outSat_q;
    out_beats = outBeats_q;
  end

endmodule

// File: tb/tb_sat_acc_adder.sv
// Randomised scoreboard bench for sat_acc_adder. A packet-level reference
// model queues expected results as beats are issued; an independent monitor
// pops and compares whenever a result is handed over downstream.
module tb_sat_acc_adder;

  localparam int     NUM_IN  = 3;
  localparam int     IN_W    = 34;
  localparam int     ACC_W   = 40;
  localparam int     OUT_W   = 16;
  localparam int     CNT_W   = 8;
  localparam longint SAT_MIN = 0;
  localparam longint SAT_MAX = 255;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;
  localparam longint LANE_MAX = (longint'(1) <<< (IN_W - 1)) - 1;
  localparam longint BEATS_MAX = (longint'(1) <<< CNT_W) - 1;

  typedef struct {
    longint data;
    bit     sat;
    longint beats;
  } exp_t;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_IN*IN_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_sat;
  logic [CNT_W-1:0]       out_beats;
`ifdef SAT_ACC_ROUND_EN
  logic [4:0]             cfg_shift;
`endif

  exp_t   expQ[$];
  exp_t   monExp;
  int     nCompared = 0;
  int     nMismatched = 0;
  int     readyMode = 0;
  longint mAcc = 0;
  bit     mOvf = 0;
  longint mCnt = 0;

  sat_acc_adder #(
    .NUM_IN  (NUM_IN),
    .IN_W    (IN_W),
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SAT_MIN (SAT_MIN),
    .SAT_MAX (SAT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
`ifdef SAT_ACC_ROUND_EN
    .cfg_shift (cfg_shift),
`endif
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_beats (out_beats)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [NUM_IN*IN_W-1:0] packLanes(input longint l0, input longint l1,
                                                        input longint l2);
    logic [NUM_IN*IN_W-1:0] d;
    d = '0;
    d[0*IN_W +: IN_W] = IN_W'(l0);
    d[1*IN_W +: IN_W] = IN_W'(l1);
    d[2*IN_W +: IN_W] = IN_W'(l2);
    return d;
  endfunction

  function automatic longint clampTo(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint randLane();
    case ($urandom_range(0, 9))
      0:       return LANE_MAX - longint'($urandom_range(0, 1000));
      1:       return -LANE_MAX - 1 + longint'($urandom_range(0, 1000));
      default: return longint'($urandom_range(0, 220)) - 60;
    endcase
  endfunction

  // Packet-level reference: running total saturates at the accumulator range,
  // the final total is optionally rescaled, then clamped to the output range.
  task automatic modelBeat(input longint l0, input longint l1, input longint l2,
                           input bit last, input int shift);
    longint raw;
    longint clamped;
    longint total;
    bit     curOvf;
    exp_t   e;
    raw     = mAcc + l0 + l1 + l2;
    clamped = clampTo(raw, ACC_MIN, ACC_MAX);
    curOvf  = (clamped != raw);
    if (!last) begin
      mAcc = clamped;
      mOvf = mOvf || curOvf;
      if (mCnt < BEATS_MAX) mCnt++;
    end else begin
      total = clamped;
      if (shift > 0) total = (total + (longint'(1) <<< (shift - 1))) >>> shift;
      e.data  = clampTo(total, SAT_MIN, SAT_MAX);
      e.sat   = (total < SAT_MIN) || (total > SAT_MAX) || mOvf || curOvf;
      e.beats = (mCnt < BEATS_MAX) ? mCnt + 1 : BEATS_MAX;
      expQ.push_back(e);
      mAcc = 0;
      mOvf = 0;
      mCnt = 0;
    end
  endtask

  task automatic clearModel();
    mAcc = 0;
    mOvf = 0;
    mCnt = 0;
    expQ.delete();
  endtask

  // Issue one beat (after optional idle gap with junk on the bus) and wait for acceptance
  task automatic applyStimulus(input longint l0, input longint l1, input longint l2,
                               input bit last, input int shift, input int maxGap);
    int           gap;
    int           waited;
    bit           done;
    logic [127:0] junk;
    gap  = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    done = 1'b0;
    waited = 0;
    repeat (gap) begin
      junk     = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b0;
      in_data  = junk[NUM_IN*IN_W-1:0];
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = packLanes(l0, l1, l2);
    in_last  = last;
`ifdef SAT_ACC_ROUND_EN
    cfg_shift = 5'(shift);
`endif
    while (!done && waited < 300) begin
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      modelBeat(l0, l1, l2, last, shift);
      if (last) begin
        @(negedge clk);
        checkOutput("latency_out_valid", longint'(out_valid), 1);
      end
    end
  endtask

  task automatic setReady(input int mode);
    readyMode = mode;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    readyMode = 2;
    while ((expQ.size() != 0 || out_valid !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", longint'(expQ.size()), 0);
  endtask

  // Downstream readiness: random backpressure, forced low, or forced high
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare against the scoreboard at every result handover
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_data", longint'(out_data), monExp.data);
        checkOutput("out_sat", longint'(out_sat), longint'(monExp.sat));
        checkOutput("out_beats", longint'(out_beats), monExp.beats);
      end
    end
  end

  initial begin
    int nb;
    int sh;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
`ifdef SAT_ACC_ROUND_EN
    cfg_shift = 5'd0;
`endif
    readyMode = 2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_data", longint'(out_data), 0);
    checkOutput("reset_out_sat", longint'(out_sat), 0);
    checkOutput("reset_out_beats", longint'(out_beats), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", longint'(in_ready), 1);

    // Directed packets from the plan plus clamp boundaries
    applyStimulus(100, 50, 60, 1, 0, 0);
    applyStimulus(100, 0, 0, 0, 0, 0);
    applyStimulus(100, 0, 0, 0, 0, 1);
    applyStimulus(100, 0, 0, 1, 0, 1);
    applyStimulus(85, 0, 0, 0, 0, 0);
    applyStimulus(0, 85, 0, 0, 0, 2);
    applyStimulus(0, 0, 85, 1, 0, 0);
    applyStimulus(-500, 0, 0, 0, 0, 0);
    applyStimulus(200, 0, 0, 1, 0, 0);
    applyStimulus(10, -10, 0, 1, 0, 0);
    applyStimulus(256, 0, 0, 1, 0, 0);
    applyStimulus(-1, 0, 0, 1, 0, 0);
    applyStimulus(255, 0, 0, 1, 0, 0);
    drain();

    // Long packet: accumulator and beat counter both saturate
    for (int b = 0; b < 300; b++) begin
      applyStimulus(LANE_MAX, LANE_MAX, LANE_MAX, (b == 299), 0, 0);
    end
    for (int b = 0; b < 30; b++) begin
      applyStimulus(-LANE_MAX - 1, -LANE_MAX - 1, -LANE_MAX - 1, (b == 29), 0, 0);
    end
    drain();

    // Held result: outputs stable and input blocked while downstream stalls
    setReady(1);
    applyStimulus(30, 20, 10, 1, 0, 0);
    in_valid = 1'b1;
    in_data  = packLanes(999, 999, 999);
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold_in_ready", longint'(in_ready), 0);
      checkOutput("hold_out_valid", longint'(out_valid), 1);
      checkOutput("hold_out_data", longint'(out_data), 60);
      checkOutput("hold_out_sat", longint'(out_sat), 0);
      checkOutput("hold_out_beats", longint'(out_beats), 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pulse_out_valid", longint'(out_valid), 0);
    checkOutput("bubble_in_ready", longint'(in_ready), 1);
    applyStimulus(7, 8, 9, 1, 0, 0);
    drain();

    // Reset while a result is pending: it must vanish
    setReady(1);
    applyStimulus(5, 5, 5, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("rst_out_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_out_data", longint'(out_data), 0);
    checkOutput("rst_out_in_ready", longint'(in_ready), 1);

    // Reset on the second beat of a packet: no residue afterwards
    readyMode = 2;
    applyStimulus(1000, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    in_data  = packLanes(2000, 0, 0);
    in_last  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    clearModel();
    applyStimulus(7, 0, 0, 1, 0, 0);
    drain();

`ifdef SAT_ACC_ROUND_EN
    // Round-half-up rescaling before the clamp
    applyStimulus(1000, 0, 0, 1, 3, 0);
    applyStimulus(1004, 0, 0, 1, 3, 0);
    applyStimulus(4000, 0, 0, 1, 2, 0);
    applyStimulus(-20, 0, 0, 1, 3, 0);
    drain();
`endif

    // Randomised packets with gaps and backpressure
    readyMode = 0;
    for (int p = 0; p < 40; p++) begin
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
`ifdef SAT_ACC_ROUND_EN
        sh = (b == nb - 1) ? int'($urandom_range(0, 4)) : 0;
`else
        sh = 0;
`endif
        applyStimulus(randLane(), randLane(), randLane(), (b == nb - 1), sh, 2);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
